// File: rtl/aes_pkg.sv
// Shared types, key-length encodings and GF(2^8) helpers for the AES key-expansion engine.
package aes_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_ILL = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DRAIN
  } ke_state_e;

  localparam byte_t RCON_INIT = 8'h01;

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // 4*(Nr+1) schedule words
  function automatic logic [5:0] total_words(key_len_e kl);
    return {nr_of(kl) + 4'd1, 2'b00};
  endfunction

  function automatic byte_t xtime(byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_subword.sv
// AES S-box lookup and the four-byte SubWord wrapper built from it; purely combinational.
module S_Box (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SBOX[i_byte];

endmodule

module aes_subword
  import aes_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    S_Box u_sbox (
      .i_byte (i_word[8*b +: 8]),
      .o_byte (o_word[8*b +: 8])
    );
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128/192/256 key schedule: one word per cycle, round keys streamed over valid/ready.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter  int unsigned MAX_NK = 8,
  localparam int unsigned KEY_W  = 32 * MAX_NK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       key_len,
  input  logic [KEY_W-1:0] key,
  output logic             busy,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic [127:0]     rk_data,
  output logic [3:0]       rk_idx,
  output logic             rk_last,
  output logic             done,
  output logic             err
);

  ke_state_e r_state, w_state_nxt;

  key_len_e  r_klen;
  logic [5:0] r_i;
  logic [2:0] r_mod;
  byte_t      r_rcon;
  word_t      r_win [8];
  word_t      r_stage [3];

  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_idx;
  logic         r_rk_valid, r_rk_last, r_done, r_err;

  word_t      w_key_words [8];
  logic [3:0] w_nk;
  logic [5:0] w_total;
  word_t      w_prev, w_sub_in, w_sub_out, w_word;
  logic       w_from_key, w_rot_step, w_sub_step;
  logic       w_start_legal, w_accept, w_stall, w_last_word;
  logic       w_load_key, w_err_set, w_advance, w_done_set, w_group;

  always_comb begin
    for (int unsigned j = 0; j < 8; j++) w_key_words[j] = '0;
    for (int unsigned j = 0; j < MAX_NK; j++) w_key_words[j] = key[KEY_W-1-32*j -: 32];
  end

  assign w_start_legal = (key_len_e'(key_len) != KL_ILL) &&
                         (32'(nk_of(key_len_e'(key_len))) <= MAX_NK);

  assign w_nk        = nk_of(r_klen);
  assign w_total     = total_words(r_klen);
  assign w_accept    = r_rk_valid && rk_ready;
  // Only the group-completing word needs the output register, so only it can stall.
  assign w_stall     = r_rk_valid && !rk_ready && (r_i[1:0] == 2'd3);
  assign w_last_word = (r_i == w_total - 6'd1);
  assign w_group     = w_advance && (r_i[1:0] == 2'd3);

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---- FSM: next state ----
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start && w_start_legal) w_state_nxt = ST_EXPAND;
      ST_EXPAND: if (w_advance && w_last_word) w_state_nxt = ST_DRAIN;
      ST_DRAIN:  if (w_accept) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_load_key = 1'b0;
    w_err_set  = 1'b0;
    w_advance  = 1'b0;
    w_done_set = 1'b0;
    busy       = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        w_load_key = start && w_start_legal;
        w_err_set  = start && !w_start_legal;
      end
      ST_EXPAND: w_advance  = !w_stall;
      ST_DRAIN:  w_done_set = w_accept;
      default: ;
    endcase
  end

  // ---- word generation ----
  // Window holds w[i-Nk]..w[i-1] at slots 0..Nk-1 once past the key words.
  assign w_prev     = r_win[3'(w_nk - 4'd1)];
  assign w_from_key = ({2'b00, w_nk} > r_i);
  assign w_rot_step = (r_mod == 3'd0);
  assign w_sub_step = (w_nk == 4'd8) && (r_mod == 3'd4);
  assign w_sub_in   = w_rot_step ? rot_word(w_prev) : w_prev;

  aes_subword u_subword (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    if (w_from_key)      w_word = r_win[r_i[2:0]];
    else if (w_rot_step) w_word = r_win[0] ^ w_sub_out ^ {r_rcon, 24'h0};
    else if (w_sub_step) w_word = r_win[0] ^ w_sub_out;
    else                 w_word = r_win[0] ^ w_prev;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_klen <= KL_128;
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= '0;
      for (int unsigned j = 0; j < 8; j++) r_win[j] <= '0;
      for (int unsigned j = 0; j < 3; j++) r_stage[j] <= '0;
    end else if (w_load_key) begin
      r_klen <= key_len_e'(key_len);
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= RCON_INIT;
      for (int unsigned j = 0; j < 8; j++) r_win[j] <= w_key_words[j];
    end else if (w_advance) begin
      r_i   <= r_i + 6'd1;
      r_mod <= (r_mod == 3'(w_nk - 4'd1)) ? 3'd0 : r_mod + 3'd1;
      case (r_i[1:0])
        2'd0:    r_stage[0] <= w_word;
        2'd1:    r_stage[1] <= w_word;
        2'd2:    r_stage[2] <= w_word;
        default: ;
      endcase
      if (!w_from_key) begin
        for (int unsigned j = 0; j < 7; j++)
          r_win[j] <= (4'(j + 1) == w_nk) ? w_word : r_win[j+1];
        if (w_nk == 4'd8) r_win[7] <= w_word;
        if (w_rot_step) r_rcon <= xtime(r_rcon);
      end
    end
  end

  // ---- round-key output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rk_data  <= '0;
      r_rk_idx   <= '0;
      r_rk_last  <= 1'b0;
      r_rk_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_group) begin
        r_rk_data  <= {r_stage[0], r_stage[1], r_stage[2], w_word};
        r_rk_idx   <= r_i[5:2];
        r_rk_last  <= w_last_word;
        r_rk_valid <= 1'b1;
      end else if (w_accept) begin
        r_rk_valid <= 1'b0;
      end
    end
  end

  assign rk_data  = r_rk_data;
  assign rk_idx   = r_rk_idx;
  assign rk_last  = r_rk_last;
  assign rk_valid = r_rk_valid;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench: key schedule model built from GF(2^8) arithmetic, random keys and backpressure.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst, start, rk_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         busy, rk_valid, rk_last, done, err;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;

  logic         start6, rk_ready6;
  logic [1:0]   key_len6;
  logic [191:0] key6;
  logic         busy6, rk_valid6, rk_last6, done6, err6;
  logic [127:0] rk_data6;
  logic [3:0]   rk_idx6;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [7:0]   sb [256];
  logic [127:0] m_rk [15];
  int           m_nr;
  logic [127:0] got [15];

  localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand #(.MAX_NK(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .key(key),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_idx(rk_idx), .rk_last(rk_last), .done(done), .err(err)
  );

  aes_key_expand #(.MAX_NK(6)) u_dut6 (
    .clk(clk), .rst(rst), .start(start6), .key_len(key_len6), .key(key6),
    .busy(busy6), .rk_valid(rk_valid6), .rk_ready(rk_ready6), .rk_data(rk_data6),
    .rk_idx(rk_idx6), .rk_last(rk_last6), .done(done6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  // S-box = multiplicative inverse followed by the FIPS-197 affine map
  task automatic init_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic build_model(input logic [1:0] kl, input logic [255:0] k);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    nk = 4 + 2 * int'(kl);
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = sub_w({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk == 8 && i % 8 == 4) begin
        t = sub_w(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    m_nr = nr;
  endtask

  task automatic run(input logic [1:0] kl, input logic [255:0] k, input bit rnd,
                     input int abort_at, input bit poke);
    int e, exp_k, errs, dones, nr;
    bit seen, stalled, fin, aborted, timed_out;
    logic [127:0] snap;
    build_model(kl, k);
    nr = m_nr;
    @(negedge clk);
    key_len = kl; key = k; start = 1'b1; rk_ready = 1'b1;
    @(posedge clk);
    e = 0; exp_k = 0; errs = 0; dones = 0;
    seen = 0; stalled = 0; fin = 0; aborted = 0; timed_out = 0; snap = '0;
    while (!fin) begin
      @(negedge clk);
      start   = 1'b0;
      key     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      key_len = 2'($urandom);
      if (poke && (e == 7 || e == 8)) start = 1'b1;
      if (abort_at > 0 && e == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_ctrl", {busy, rk_valid, rk_last, done, err, rk_idx}, '0);
        check("abort_data", rk_data, '0);
        rst = 1'b0;
        dones = 0;
        repeat (60) begin
          @(negedge clk);
          if (done || rk_valid || busy) dones++;
        end
        check("abort_quiet", dones, 0);
        aborted = 1;
        break;
      end
      if (err)  errs++;
      if (done) dones++;
      if (rk_valid) begin
        if (!seen) begin
          seen = 1;
          if (!rnd) check($sformatf("rk%0d_latency", exp_k), e, 4 * (exp_k + 1));
          check($sformatf("rk%0d_data", exp_k), rk_data, m_rk[exp_k]);
          check($sformatf("rk%0d_idx", exp_k), rk_idx, exp_k);
          check($sformatf("rk%0d_last", exp_k), rk_last, exp_k == nr);
        end else if (stalled) begin
          check($sformatf("rk%0d_stable", exp_k), {rk_idx, rk_last, rk_data}, {4'(exp_k), exp_k == nr, snap});
        end
      end
      rk_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rk_valid && rk_ready) begin
        if (exp_k < 15) got[exp_k] = rk_data;
        if (exp_k == nr) fin = 1;
        exp_k++;
        seen = 0; stalled = 0;
      end else if (rk_valid) begin
        stalled = 1; snap = rk_data;
      end
      @(posedge clk);
      e++;
      if (e > 600) begin
        check("timeout_keys", exp_k, nr + 1);
        timed_out = 1;
        fin = 1;
      end
    end
    if (!aborted && !timed_out) begin
      @(negedge clk);
      check("done_pulse", {done, busy, rk_valid}, 3'b100);
      @(negedge clk);
      check("done_clear", done, 0);
      check("key_count", exp_k, nr + 1);
      check("no_err_in_run", errs, 0);
      check("no_early_done", dones, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; key_len = 2'd0; key = '0; rk_ready = 1'b0;
    start6 = 1'b0; key_len6 = 2'd0; key6 = '0; rk_ready6 = 1'b1;
    init_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {busy, rk_valid, rk_last, done, err, rk_idx}, '0);
    check("reset_data", rk_data, '0);
    rst = 1'b0;

    run(2'd0, {K128, 128'h0}, 0, 0, 0);
    check("aes128_rk0", got[0], K128);
    check("aes128_rk1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("aes128_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run(2'd1, {K192, 64'h0}, 0, 0, 0);
    check("aes192_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);

    run(2'd2, K256, 0, 0, 0);
    check("aes256_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    run(2'd2, K256, 1, 0, 0);
    check("aes256_bp_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

    @(negedge clk); start = 1'b1; key_len = 2'd3;
    @(negedge clk); start = 1'b0;
    check("err_kl3", {err, busy, rk_valid}, 3'b100);
    @(negedge clk);
    check("err_kl3_once", {err, busy, rk_valid}, 3'b000);

    @(negedge clk); start6 = 1'b1; key_len6 = 2'd2;
    @(negedge clk); start6 = 1'b0;
    check("err_nk6", {err6, busy6, rk_valid6}, 3'b100);
    @(negedge clk);
    check("err_nk6_once", {err6, busy6, rk_valid6}, 3'b000);

    run(2'd0, {K128, 128'h0}, 0, 20, 0);
    run(2'd0, {K128, 128'h0}, 0, 0, 1);
    check("rerun_rk0", got[0], K128);
    check("rerun_rk10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int r = 0; r < 6; r++)
      run(2'(r % 3),
          {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
          1, 0, r[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key-expansion engine for AES-128, AES-192 and AES-256 (FIPS-197), with the key length selected per run.
- Produces one 32-bit schedule word per cycle and streams each 128-bit round key out through a valid/ready handshake, in round order 0..Nr.
- Sits between the key register and the round datapath. It replaces one-round-per-instance key logic with a single shared generator.

Parameters:
- MAX_NK, 8, largest supported key length in words (4, 6 or 8). Modes with Nk > MAX_NK are rejected.
- KEY_W, 32*MAX_NK, derived width of the key port. Not to be overridden.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new expansion; sampled only in IDLE
- key_len  in  2  key length: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = illegal
- key  in  KEY_W  cipher key, left-justified: key[KEY_W-1 -: 32] = w0; unused low bits are ignored
- busy  out  1  high from the edge that accepts start until done
- rk_valid  out  1  rk_data holds an unaccepted round key
- rk_ready  in  1  consumer accepts rk_data when rk_valid && rk_ready
- rk_data  out  128  round key, {w[4k], w[4k+1], w[4k+2], w[4k+3]}, w[4k] in the MSBs
- rk_idx  out  4  round index k of rk_data
- rk_last  out  1  rk_data is round key Nr
- done  out  1  one-cycle pulse on the edge after the last round key is accepted
- err  out  1  one-cycle pulse when start arrives with an illegal or unsupported key_len

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and internal registers are cleared. A reset asserted mid-run aborts the run; no done pulse follows.
- Run parameters: Nk = 4/6/8 and Nr = 10/12/14 for key_len 0/1/2. Total words = 4(Nr+1) = 44/52/60.
- FSM states:
  - IDLE: on start with a legal key_len, latch key and key_len, clear the word counter i, set Rcon = 0x01, go to EXPAND, set busy. With an illegal key_len, pulse err and stay in IDLE.
  - EXPAND: produce word w[i] each non-stalled cycle.
  - DRAIN: after w[last] has been written to the output register, wait for acceptance. On acceptance pulse done, clear busy, return to IDLE.
- Word rule:
  - i < Nk: w[i] comes from the key.
  - Otherwise let t = w[i-1].
  - If i mod Nk == 0: t = SubWord(RotWord(t)) ^ {Rcon, 24'h0}, then Rcon = xtime(Rcon); 0x80 becomes 0x1b.
  - Else if Nk == 8 and i mod 8 == 4: t = SubWord(t).
  - w[i] = w[i-Nk] ^ t.
  - RotWord rotates left by one byte.
- Storage: a sliding window of the last Nk words and a 4-word staging buffer.
- Round-key emission: when the staging buffer holds 4 words, load rk_data, rk_idx = i/4 and rk_last, and set rk_valid.
- Stall rule: hold word generation (i, window and Rcon all frozen) when rk_valid && !rk_ready and the next word would complete a group.
- An accepted key frees the output register in the same cycle, so a new key may load on the same edge.
- Latency with rk_ready held high: round key k is valid after edge 4(k+1), counting from the edge that samples start. rk_valid stays high continuously from key 0 onward. done follows the edge on which key Nr is accepted.
- Handshake rules:
  - rk_data, rk_idx and rk_last are stable while rk_valid && !rk_ready.
  - rk_valid never drops without acceptance, except under rst.
- start while busy is ignored and does not pulse err. key and key_len may change freely after the start edge.

Decomposition:
- aes_pkg holds:
  - key_len encodings
  - Nk/Nr lookup functions
  - the xtime function and Rcon initial value
  - SubWord/RotWord helper typedefs
- Sub-module aes_subword: four instances of the existing S_Box, one per byte, purely combinational. It is instantiated once and shared between the RotWord and plain-SubWord paths.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready = 1:
  - rk0 equals the key.
  - rk1 = a0fafe1788542cb123a339392a6c7605.
  - rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last = 1, valid after edge 44.
  - done pulses on the edge after rk10 is accepted.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: 13 keys; rk12 = e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: 15 keys; rk14 = fe4890d1e6188d0b046df344706c631e.
- Random rk_ready backpressure on the AES-256 run:
  - identical key sequence;
  - rk_data is stable while stalled;
  - no key is dropped or duplicated;
  - rk_idx increments by exactly 1 per accept.
- key_len = 3, and key_len = 2 with MAX_NK = 6: err pulses for 1 cycle, busy stays 0, rk_valid stays 0.
- rst asserted at cycle 20 of an AES-128 run: all outputs read 0 the next cycle and no done pulse. A new start then reproduces rk0..rk10 exactly; start pulses while busy are ignored.
